// File: rtl/pid_pkg.sv
// Shared types and saturating helpers for the multiplexed PID servo datapath.
// Combinational helpers only; no latency, no flow control.
package pid_pkg;

    localparam int ACC_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        ACC,
        SUM,
        DONE
    } state_t;

    function automatic logic signed [ACC_W-1:0] sat_signed(
        input logic signed [ACC_W-1:0] v,
        input logic signed [ACC_W-1:0] lim
    );
        if (v > lim) begin
            return lim;
        end else if (v < -lim) begin
            return -lim;
        end else begin
            return v;
        end
    endfunction

    function automatic logic [7:0] clamp_pos(
        input logic signed [ACC_W-1:0] v,
        input logic signed [ACC_W-1:0] lo,
        input logic signed [ACC_W-1:0] hi
    );
        if (v < lo) begin
            return lo[7:0];
        end else if (v > hi) begin
            return hi[7:0];
        end else begin
            return v[7:0];
        end
    endfunction

endpackage

// File: rtl/pid_multi_servo_if.sv
// Servo controller bus: sampling enable, packed position inputs, published positions and status.
// No handshake; pos_valid is a one-cycle strobe that the consumer must not stall.
interface pid_multi_servo_if #(
    parameter int NUM_CH = 2,
    parameter int DW     = 8
);
    logic                   enable;
    logic [NUM_CH*DW-1:0]   desired_pos;
    logic [NUM_CH*DW-1:0]   current_pos;
    logic [NUM_CH*8-1:0]    pos_out;
    logic                   pos_valid;
    logic                   busy;
    logic                   overrun;

    modport master (
        output enable, desired_pos, current_pos,
        input  pos_out, pos_valid, busy, overrun
    );

    modport slave (
        input  enable, desired_pos, current_pos,
        output pos_out, pos_valid, busy, overrun
    );
endinterface

// File: rtl/pid_sample_tick.sv
// Free-running sample divider: tick is high in the last cycle of each SAMPLE_DIV period.
// Tick is combinational from the counter; enable low parks the counter at zero.
module pid_sample_tick #(
    parameter int SAMPLE_DIV = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);
    localparam int             CW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!enable || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = enable && (cnt == LAST);
endmodule

// File: rtl/pid_multi_servo.sv
// Multi-channel PID servo: one shared datapath, 3 cycles per channel, positions published together.
// Tick at T gives pos_out/pos_valid at T+3*NUM_CH+2; ticks arriving mid-sweep are dropped and flag overrun.
module pid_multi_servo
    import pid_pkg::*;
#(
    parameter int DW         = 8,
    parameter int NUM_CH     = 2,
    parameter int SAMPLE_DIV = 500,
    parameter int KP         = 1,
    parameter int KI         = 1,
    parameter int KD         = -1,
    parameter int SHIFT      = 2,
    parameter int I_LIM      = 127,
    parameter int CENTER     = 90,
    parameter int POS_MIN    = 0,
    parameter int POS_MAX    = 180
) (
    input  logic                 clk,
    input  logic                 rst,
    pid_multi_servo_if.slave     bus
);
    localparam int                       CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0]          LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic signed [ACC_W-1:0]  KP_S     = ACC_W'(KP);
    localparam logic signed [ACC_W-1:0]  KI_S     = ACC_W'(KI);
    localparam logic signed [ACC_W-1:0]  KD_S     = ACC_W'(KD);
    localparam logic signed [ACC_W-1:0]  ILIM_S   = ACC_W'(I_LIM);
    localparam logic signed [ACC_W-1:0]  CENTER_S = ACC_W'(CENTER);
    localparam logic signed [ACC_W-1:0]  MIN_S    = ACC_W'(POS_MIN);
    localparam logic signed [ACC_W-1:0]  MAX_S    = ACC_W'(POS_MAX);
    localparam logic [7:0]               CENTER8  = 8'(CENTER);

    logic tick;

    pid_sample_tick #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (bus.enable),
        .tick   (tick)
    );

    state_t                  state;
    logic [CH_W-1:0]         ch;
    logic signed [DW-1:0]    des_s   [NUM_CH];
    logic signed [DW-1:0]    cur_s   [NUM_CH];
    logic signed [DW:0]      e_prev  [NUM_CH];
    logic signed [ACC_W-1:0] integ   [NUM_CH];
    logic [7:0]              shadow  [NUM_CH];
    logic signed [DW:0]      e_r;
    logic signed [DW+1:0]    d_r;
    logic signed [ACC_W-1:0] i_new_r;
    logic [NUM_CH*8-1:0]     pos_out_r;
    logic                    pos_valid_r;
    logic                    busy_r;
    logic                    overrun_r;

    logic signed [ACC_W-1:0] pid_sum;
    logic signed [ACC_W-1:0] u;
    logic signed [ACC_W-1:0] p_full;
    logic [7:0]              p;
    logic                    hold_integ;

    // Integration is frozen only when the output saturates and the error keeps pushing further out.
    always_comb begin
        pid_sum    = KP_S * ACC_W'(e_r) + KI_S * i_new_r + KD_S * ACC_W'(d_r);
        u          = pid_sum >>> SHIFT;
        p_full     = CENTER_S + u;
        p          = clamp_pos(p_full, MIN_S, MAX_S);
        hold_integ = ((p_full < MIN_S) || (p_full > MAX_S)) &&
                     (e_r[DW] == u[ACC_W-1]) &&
                     ((e_r == '0) == (u == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ch          <= '0;
            e_r         <= '0;
            d_r         <= '0;
            i_new_r     <= '0;
            pos_out_r   <= {NUM_CH{CENTER8}};
            pos_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
            for (int n = 0; n < NUM_CH; n++) begin
                des_s[n]  <= '0;
                cur_s[n]  <= '0;
                e_prev[n] <= '0;
                integ[n]  <= '0;
                shadow[n] <= CENTER8;
            end
        end else begin
            pos_valid_r <= 1'b0;
            if (tick && state != IDLE) begin
                overrun_r <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick) begin
                        for (int n = 0; n < NUM_CH; n++) begin
                            des_s[n] <= bus.desired_pos[n*DW +: DW];
                            cur_s[n] <= bus.current_pos[n*DW +: DW];
                        end
                        ch     <= '0;
                        busy_r <= 1'b1;
                        state  <= ERR;
                    end
                end
                ERR: begin
                    e_r   <= (DW+1)'(des_s[ch]) - (DW+1)'(cur_s[ch]);
                    state <= ACC;
                end
                ACC: begin
                    i_new_r <= sat_signed(integ[ch] + ACC_W'(e_r), ILIM_S);
                    d_r     <= (DW+2)'(e_r) - (DW+2)'(e_prev[ch]);
                    state   <= SUM;
                end
                SUM: begin
                    shadow[ch] <= p;
                    e_prev[ch] <= e_r;
                    if (!hold_integ) begin
                        integ[ch] <= i_new_r;
                    end
                    if (ch == LAST_CH) begin
                        state <= DONE;
                    end else begin
                        ch    <= ch + 1'b1;
                        state <= ERR;
                    end
                end
                DONE: begin
                    for (int n = 0; n < NUM_CH; n++) begin
                        pos_out_r[n*8 +: 8] <= shadow[n];
                    end
                    pos_valid_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pos_out   = pos_out_r;
    assign bus.pos_valid = pos_valid_r;
    assign bus.busy      = busy_r;
    assign bus.overrun   = overrun_r;
endmodule

// File: tb/tb_pid_multi_servo.sv
// Four controller instances with different gains/dividers; directed sweeps feed a scoreboard.
// A single negedge monitor checks published positions, their timing and scheduled status samples.
module tb_pid_multi_servo;
    logic        clk;
    logic        rst;
    logic [3:0]  en;
    logic [15:0] des;
    logic [15:0] cur;
    logic        done;
    int          cyc;
    int          checks;
    int          errors;

    typedef struct {
        int          d;
        logic [15:0] pos;
        int          cyc;
    } exp_t;

    typedef struct {
        int          cyc;
        int          d;
        int          sig;
        logic [15:0] val;
    } st_t;

    exp_t sb[$];
    st_t  stq[$];

    pid_multi_servo_if #(.NUM_CH(2), .DW(8)) ia ();
    pid_multi_servo_if #(.NUM_CH(2), .DW(8)) ib ();
    pid_multi_servo_if #(.NUM_CH(2), .DW(8)) ic ();
    pid_multi_servo_if #(.NUM_CH(2), .DW(8)) id ();

    assign ia.enable = en[0];
    assign ib.enable = en[1];
    assign ic.enable = en[2];
    assign id.enable = en[3];
    assign ia.desired_pos = des;
    assign ib.desired_pos = des;
    assign ic.desired_pos = des;
    assign id.desired_pos = des;
    assign ia.current_pos = cur;
    assign ib.current_pos = cur;
    assign ic.current_pos = cur;
    assign id.current_pos = cur;

    pid_multi_servo #(.SAMPLE_DIV(16), .KP(2), .KI(0), .KD(0), .SHIFT(0)) ua (
        .clk(clk), .rst(rst), .bus(ia));
    pid_multi_servo #(.SAMPLE_DIV(16), .KP(0), .KI(1), .KD(0), .SHIFT(0), .I_LIM(50)) ub (
        .clk(clk), .rst(rst), .bus(ib));
    pid_multi_servo #(.SAMPLE_DIV(16), .KP(0), .KI(0), .KD(1), .SHIFT(0)) uc (
        .clk(clk), .rst(rst), .bus(ic));
    pid_multi_servo #(.SAMPLE_DIV(4), .KP(1), .KI(0), .KD(0), .SHIFT(0)) ud (
        .clk(clk), .rst(rst), .bus(id));

    logic [15:0] po [4];
    logic [3:0]  pv, bz, ov;
    assign po[0] = ia.pos_out;
    assign po[1] = ib.pos_out;
    assign po[2] = ic.pos_out;
    assign po[3] = id.pos_out;
    assign pv = {id.pos_valid, ic.pos_valid, ib.pos_valid, ia.pos_valid};
    assign bz = {id.busy, ic.busy, ib.busy, ia.busy};
    assign ov = {id.overrun, ic.overrun, ib.overrun, ia.overrun};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] sel(input int d, input int sig);
        case (sig)
            0:       return po[d];
            1:       return {15'd0, pv[d]};
            2:       return {15'd0, bz[d]};
            default: return {15'd0, ov[d]};
        endcase
    endfunction

    // Monitor: sole owner of the check/error counters.
    exp_t        m_e;
    st_t         m_s;
    logic [15:0] m_act;
    initial begin
        checks = 0;
        errors = 0;
    end
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (pv[d]) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid dut%0d cyc=%0d pos_out=%h", d, cyc, po[d]);
                end else begin
                    m_e = sb.pop_front();
                    if (m_e.d != d || m_e.cyc != cyc || m_e.pos != po[d]) begin
                        errors++;
                        $display("FAIL sweep got dut%0d cyc=%0d pos_out=%h want dut%0d cyc=%0d pos_out=%h",
                                 d, cyc, po[d], m_e.d, m_e.cyc, m_e.pos);
                    end
                end
            end
        end
        while (stq.size() > 0 && stq[0].cyc <= cyc) begin
            m_s   = stq.pop_front();
            m_act = sel(m_s.d, m_s.sig);
            checks++;
            if (m_act != m_s.val) begin
                errors++;
                $display("FAIL status dut%0d sig%0d cyc=%0d got=%h want=%h",
                         m_s.d, m_s.sig, cyc, m_act, m_s.val);
            end
        end
        if (done || cyc > 5000) begin
            checks++;
            if (!done) begin
                errors++;
                $display("FAIL timeout cyc=%0d", cyc);
            end else if (sb.size() != 0 || stq.size() != 0) begin
                errors++;
                $display("FAIL missing_events got=%0d want=0", sb.size() + stq.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    task automatic sched(input int c, input int d, input int sig, input logic [15:0] v);
        st_t s;
        s.cyc = c; s.d = d; s.sig = sig; s.val = v;
        stq.push_back(s);
    endtask

    task automatic expect_pos(input int d, input logic [15:0] p, input int c);
        exp_t e;
        e.d = d; e.pos = p; e.cyc = c;
        sb.push_back(e);
    endtask

    // One enable window on a SAMPLE_DIV=16 instance; tick lands at k+15, result at k+23.
    task automatic run(input int d, input logic [15:0] dv, input logic [15:0] cv,
                       input int n, input logic [15:0] ex);
        int k;
        @(negedge clk);
        des   = dv;
        cur   = cv;
        en[d] = 1'b1;
        k     = cyc;
        for (int j = 0; j < n; j++) expect_pos(d, ex, k + 23 + j * 16);
        sched(k + 16, d, 2, 16'd1);
        sched(k + 22, d, 2, 16'd1);
        sched(k + 23, d, 2, 16'd0);
        repeat (n * 16 + 10) @(negedge clk);
        en[d] = 1'b0;
    endtask

    initial begin
        int k;
        rst  = 1'b1;
        en   = '0;
        des  = '0;
        cur  = '0;
        done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 4; d++) begin
            sched(cyc + 1, d, 0, {8'd90, 8'd90});
            sched(cyc + 1, d, 1, 16'd0);
            sched(cyc + 1, d, 2, 16'd0);
            sched(cyc + 1, d, 3, 16'd0);
        end

        // Idle inputs, then proportional step and both clamps.
        run(0, 16'h0000, 16'h0000, 3, {8'd90, 8'd90});
        run(0, {8'd0, 8'd10}, 16'h0000, 1, {8'd90, 8'd110});
        run(0, {8'd0, 8'h64}, {8'd0, 8'h9C}, 1, {8'd90, 8'd180});
        run(0, {8'd0, 8'h9C}, {8'd0, 8'h64}, 1, {8'd90, 8'd0});

        // Integral with I_LIM=50 under constant error 20.
        run(1, {8'd0, 8'd20}, 16'h0000, 1, {8'd90, 8'd110});
        run(1, {8'd0, 8'd20}, 16'h0000, 1, {8'd90, 8'd130});
        run(1, {8'd0, 8'd20}, 16'h0000, 1, {8'd90, 8'd140});
        run(1, {8'd0, 8'd20}, 16'h0000, 1, {8'd90, 8'd140});

        // Derivative: error 0, 8, 8.
        run(2, 16'h0000, 16'h0000, 1, {8'd90, 8'd90});
        run(2, {8'd0, 8'd8}, 16'h0000, 1, {8'd90, 8'd98});
        run(2, {8'd0, 8'd8}, 16'h0000, 1, {8'd90, 8'd90});

        // Divider of 4 against an 8-cycle sweep: every other tick is dropped.
        @(negedge clk);
        des   = {8'd0, 8'd20};
        cur   = 16'h0000;
        en[3] = 1'b1;
        k     = cyc;
        expect_pos(3, {8'd90, 8'd110}, k + 11);
        expect_pos(3, {8'd90, 8'd110}, k + 19);
        expect_pos(3, {8'd90, 8'd110}, k + 27);
        sched(k + 7, 3, 3, 16'd0);
        sched(k + 8, 3, 3, 16'd1);
        sched(k + 29, 3, 2, 16'd1);
        sched(k + 31, 3, 0, {8'd90, 8'd90});
        sched(k + 31, 3, 1, 16'd0);
        sched(k + 31, 3, 2, 16'd0);
        sched(k + 31, 3, 3, 16'd0);
        sched(k + 35, 3, 1, 16'd0);
        repeat (30) @(negedge clk);
        @(posedge clk);
        #2;
        rst   = 1'b1;
        en[3] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        done = 1'b1;
    end
endmodule
